// File: rtl/xor_parity_accum.sv
// Frame-based XOR parity accumulator with a valid/ready input and a held result.
// Optional XOR_PARITY_ACCUM_CHECK_EN adds exp_bit/err result checking.
module xor_parity_accum #(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_parity,
  output logic             out_bit,
`ifdef XOR_PARITY_ACCUM_CHECK_EN
  input  logic             exp_bit,
  output logic             err,
`endif
  output logic [CNT_W-1:0] out_count
);

  localparam logic ACCUM = 1'b0;
  localparam logic HOLD  = 1'b1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  logic             state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_parity_q, res_parity_d;
  logic [CNT_W-1:0] res_count_q, res_count_d;

  logic             accept;
  logic             take;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] cnt_next;

  assign accept   = in_valid && (state_q == ACCUM);
  assign take     = (state_q == HOLD) && out_ready;
  assign acc_next = acc_q ^ in_data;
  assign cnt_next = cnt_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    res_parity_d = res_parity_q;
    res_count_d  = res_count_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d = acc_next;
          cnt_d = cnt_next;
          // Closing word: capture the result so out_* stay put until the next frame closes.
          if (in_last || (cnt_q == LAST_CNT)) begin
            state_d      = HOLD;
            res_parity_d = acc_next;
            res_count_d  = cnt_next;
          end
        end
      end
      default: begin
        if (take) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ACCUM;
      acc_q        <= '0;
      cnt_q        <= '0;
      res_parity_q <= '0;
      res_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      res_parity_q <= res_parity_d;
      res_count_q  <= res_count_d;
    end
  end

  assign in_ready   = (state_q == ACCUM);
  assign out_valid  = (state_q == HOLD);
  assign out_parity = res_parity_q;
  assign out_bit    = ^res_parity_q;
  assign out_count  = res_count_q;

`ifdef XOR_PARITY_ACCUM_CHECK_EN
  logic err_q;

  // Sticky until reset; only evaluated on a result handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (take && (out_bit != exp_bit)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: doc/xor_parity_accum.md
XOR_PARITY_ACCUM -- requirements
Module: xor_parity_accum

Interface
REQ-001 Parameter WIDTH, default 3, SHALL set the data lane width (gate input count); legal 1..32.
REQ-002 Parameter FRAME_LEN, default 8, SHALL set the maximum words per frame; legal 1..256.
REQ-003 Parameter CNT_W, default $clog2(FRAME_LEN+1), SHALL set the word-count width.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_valid  input  1  in_data/in_last are valid this cycle.
REQ-007 in_ready  output  1  block accepts a word this cycle.
REQ-008 in_data  input  WIDTH  word to fold into the running XOR.
REQ-009 in_last  input  1  marks the final word of a short frame.
REQ-010 out_valid  output  1  frame result is held on the out_* outputs.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 out_parity  output  WIDTH  bitwise XOR of all words in the frame.
REQ-013 out_bit  output  1  reduction XOR of out_parity (overall odd parity of the frame).
REQ-014 out_count  output  CNT_W  number of words in the frame, 1..FRAME_LEN.

Function
REQ-015 A word SHALL be accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-016 The FSM SHALL have two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-017 In ACCUM, an accepted word SHALL update acc <= acc ^ in_data and cnt <= cnt+1.
REQ-018 ACCUM->HOLD SHALL occur on the accept with in_last=1 or with cnt==FRAME_LEN-1, whichever comes first.
REQ-019 out_valid SHALL assert on the cycle after the closing accept (latency 1); out_parity SHALL equal the XOR of all accepted words, including the closing word.
REQ-020 out_parity, out_bit and out_count SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 HOLD->ACCUM SHALL occur on the cycle with out_valid=1 and out_ready=1; acc and cnt SHALL clear to 0 on that edge.
REQ-022 in_ready SHALL be 0 throughout HOLD, including the handshake cycle; the next frame's first word SHALL be accepted no earlier than the following cycle.
REQ-023 in_valid=1 with in_ready=0 SHALL have no effect on acc or cnt.
REQ-024 FRAME_LEN=1 SHALL close every frame on its first word, with out_count=1.
REQ-025 cnt SHALL never exceed FRAME_LEN; wrap-around SHALL be impossible.
REQ-026 in_last on the FRAME_LEN-th word SHALL close the frame exactly once.

Reset
REQ-027 While rst=1 at a clock edge, the FSM SHALL go to ACCUM with acc=0, cnt=0, out_valid=0 and in_ready=1 after the edge.
REQ-028 Reset mid-frame or in HOLD SHALL discard the partial or held result; no out_valid pulse SHALL follow.
REQ-029 out_parity=0, out_bit=0 and out_count=0 SHALL hold from reset until the first result.

Configuration
REQ-030 Macro XOR_PARITY_ACCUM_CHECK_EN SHALL, when defined, add input exp_bit (1) and output err (1).
REQ-031 With the macro defined, err SHALL set (sticky) on a result handshake where out_bit != exp_bit, and SHALL clear only on rst.
REQ-032 Without the macro, exp_bit and err SHALL be absent and behaviour SHALL be otherwise identical.

Verification
REQ-033 WIDTH=3, FRAME_LEN=8, sweep in_data 0..7 with in_valid=1 and out_ready=1 -> one cycle later out_parity=3'b000, out_bit=0, out_count=8.
REQ-034 Words 3'b101, 3'b011 with in_last on the second -> out_parity=3'b110, out_bit=0, out_count=2.
REQ-035 Hold out_ready=0 for 5 cycles after a result -> out_* stable and in_ready=0 throughout; a word presented during HOLD is not accepted.
REQ-036 rst asserted after 4 of 8 words, then a full frame of 3'b001 x8 -> out_parity=3'b000, out_count=8; no earlier out_valid.
REQ-037 FRAME_LEN=1, word 3'b111 -> out_parity=3'b111, out_bit=1, out_count=1.
REQ-038 With the macro defined, exp_bit=0 on the REQ-037 result -> err=1 and stays 1 across later frames until rst.
